// File: rtl/sram_port_master.sv
// -----------------------------------------------------------------------------
// sram_port_master
//
// Purpose:
//   Request/response front end for the single-port, byte-masked cache data
//   SRAM macros. It takes one read or write request at a time from the cache
//   datapath and drives the macro pins with the timing the macro expects:
//     - The macro captures its inputs at posedge.
//     - A write commits, and dout0 updates, at the following negedge.
//   It then returns either the read data or a write acknowledgement.
//
//   Sequence: IDLE -(accept)-> ISSUE -> [CAPT, reads only] -> RESP -> IDLE
//
// Optional feature:
//   Define SRAM_PORT_STATS_EN to add the saturating stat_reads / stat_writes
//   counters. Each one counts accepted requests of its kind.
//
// Ports:
//   clk, rst_n              clock and synchronous active-low reset
//   req_valid/req_ready     request handshake
//   req_write               request is a write (1) or a read (0)
//   req_addr/wdata/wmask    request address, write data and byte enables
//   resp_valid/resp_ready   response handshake
//   resp_write/resp_rdata   response kind (1 = write ack) and read data
//   csb0, web0              SRAM chip select and write enable (active low)
//   wmask0, addr0, din0     SRAM byte mask, address and write data
//   dout0                   SRAM read data
//   stat_reads/stat_writes  request counters (SRAM_PORT_STATS_EN only)
// -----------------------------------------------------------------------------
module sram_port_master #(
    parameter  int ADDR_WIDTH = 5,
    parameter  int DATA_WIDTH = 256,
    localparam int NUM_WMASKS = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [NUM_WMASKS-1:0] req_wmask,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic                  resp_write,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  csb0,
    output logic                  web0,
    output logic [NUM_WMASKS-1:0] wmask0,
    output logic [ADDR_WIDTH-1:0] addr0,
    output logic [DATA_WIDTH-1:0] din0,
    input  logic [DATA_WIDTH-1:0] dout0
`ifdef SRAM_PORT_STATS_EN
    ,
    output logic [31:0]           stat_reads,
    output logic [31:0]           stat_writes
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_CAPT,
        S_RESP
    } state_t;

    state_t                r_state,      w_state;
    logic                  r_write,      w_write;
    logic                  r_csb0,       w_csb0;
    logic                  r_web0,       w_web0;
    logic [NUM_WMASKS-1:0] r_wmask0,     w_wmask0;
    logic [ADDR_WIDTH-1:0] r_addr0,      w_addr0;
    logic [DATA_WIDTH-1:0] r_din0,       w_din0;
    logic                  r_resp_valid, w_resp_valid;
    logic                  r_resp_write, w_resp_write;
    logic [DATA_WIDTH-1:0] r_resp_rdata, w_resp_rdata;
    logic                  w_accept;

    // A request is taken only in IDLE and never while reset is held. Gating
    // with rst_n keeps req_ready low for the whole reset window, including
    // the cycles when the state register already reads IDLE.
    assign req_ready = rst_n && (r_state == S_IDLE);
    assign w_accept  = req_ready && req_valid;

    // Next-state and next-output logic.
    // NOTE: every signal gets a default at the top of the block, so no path
    // leaves one unassigned. This prevents latch inference.
    always_comb begin
        w_state      = r_state;
        w_write      = r_write;
        w_csb0       = 1'b1;          // deselected unless issuing this cycle
        w_web0       = 1'b1;          // web0 stays high whenever csb0 is high
        w_wmask0     = r_wmask0;
        w_addr0      = r_addr0;
        w_din0       = r_din0;
        w_resp_valid = r_resp_valid;
        w_resp_write = r_resp_write;
        w_resp_rdata = r_resp_rdata;

        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_write = req_write;
                    w_csb0  = 1'b0;
                    w_web0  = ~req_write;
                    w_addr0 = req_addr;
                    if (req_write) begin
                        w_din0   = req_wdata;
                        w_wmask0 = req_wmask;
                    end else begin
                        // din0 keeps its old value. The macro ignores it on reads.
                        w_wmask0 = '0;
                    end
                    w_state = S_ISSUE;
                end
            end

            S_ISSUE: begin
                // The macro latched the command at this edge. A write needs
                // nothing more from us, so it is acknowledged straight away.
                if (r_write) begin
                    w_resp_valid = 1'b1;
                    w_resp_write = 1'b1;
                    w_state      = S_RESP;
                end else begin
                    w_state = S_CAPT;
                end
            end

            S_CAPT: begin
                // dout0 settled at the negedge after the issue edge.
                w_resp_rdata = dout0;
                w_resp_valid = 1'b1;
                w_resp_write = 1'b0;
                w_state      = S_RESP;
            end

            S_RESP: begin
                if (resp_ready) begin
                    w_resp_valid = 1'b0;
                    w_state      = S_IDLE;
                end
            end

            default: w_state = S_IDLE;
        endcase
    end

    // State and output registers.
    // NOTE: sequential state uses non-blocking assignments. Every register
    // then samples the values from before the edge, whatever the statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_write      <= 1'b0;
            r_csb0       <= 1'b1;
            r_web0       <= 1'b1;
            r_wmask0     <= '0;
            r_addr0      <= '0;
            r_din0       <= '0;
            r_resp_valid <= 1'b0;
            r_resp_write <= 1'b0;
            r_resp_rdata <= '0;
        end else begin
            r_state      <= w_state;
            r_write      <= w_write;
            r_csb0       <= w_csb0;
            r_web0       <= w_web0;
            r_wmask0     <= w_wmask0;
            r_addr0      <= w_addr0;
            r_din0       <= w_din0;
            r_resp_valid <= w_resp_valid;
            r_resp_write <= w_resp_write;
            r_resp_rdata <= w_resp_rdata;
        end
    end

    assign csb0       = r_csb0;
    assign web0       = r_web0;
    assign wmask0     = r_wmask0;
    assign addr0      = r_addr0;
    assign din0       = r_din0;
    assign resp_valid = r_resp_valid;
    assign resp_write = r_resp_write;
    assign resp_rdata = r_resp_rdata;

`ifdef SRAM_PORT_STATS_EN
    logic [31:0] r_stat_reads;
    logic [31:0] r_stat_writes;

    // The counters count accepted requests. They stop at all-ones rather
    // than wrapping back to zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stat_reads  <= '0;
            r_stat_writes <= '0;
        end else if (w_accept) begin
            if (req_write) begin
                if (r_stat_writes != 32'hFFFF_FFFF) r_stat_writes <= r_stat_writes + 32'd1;
            end else begin
                if (r_stat_reads != 32'hFFFF_FFFF) r_stat_reads <= r_stat_reads + 32'd1;
            end
        end
    end

    assign stat_reads  = r_stat_reads;
    assign stat_writes = r_stat_writes;
`endif

endmodule

// File: tb/tb_sram_port_master.sv
// -----------------------------------------------------------------------------
// tb_sram_port_master
//
// Directed testbench for sram_port_master. It contains a behavioural model of
// the byte-masked SRAM macro:
//   - The command is captured at posedge.
//   - A write commits, or dout0 updates, at the following negedge.
// DUT outputs are sampled at negedge. Inputs are driven at negedge.
// Define SRAM_PORT_STATS_EN to include the request counters.
// -----------------------------------------------------------------------------
module tb_sram_port_master;

    localparam int AW = 5;
    localparam int DW = 256;
    localparam int MW = DW / 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid, req_ready, req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [MW-1:0] req_wmask;
    logic          resp_valid, resp_ready, resp_write;
    logic [DW-1:0] resp_rdata;
    logic          csb0, web0;
    logic [MW-1:0] wmask0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] din0;
    logic [DW-1:0] dout0;
`ifdef SRAM_PORT_STATS_EN
    logic [31:0]   stat_reads, stat_writes;
`endif

    sram_port_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wmask  (req_wmask),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_write (resp_write),
        .resp_rdata (resp_rdata),
        .csb0       (csb0),
        .web0       (web0),
        .wmask0     (wmask0),
        .addr0      (addr0),
        .din0       (din0),
        .dout0      (dout0)
`ifdef SRAM_PORT_STATS_EN
        ,
        .stat_reads (stat_reads),
        .stat_writes(stat_writes)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- SRAM macro model ----------------
    logic [DW-1:0] mem [2**AW];
    logic          s_csb = 1'b1;
    logic          s_web = 1'b1;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_din;
    logic [MW-1:0] s_mask;

    initial begin
        for (int i = 0; i < 2**AW; i++) mem[i] = '0;
        dout0 = '0;
    end

    always @(posedge clk) begin
        s_csb  <= csb0;
        s_web  <= web0;
        s_addr <= addr0;
        s_din  <= din0;
        s_mask <= wmask0;
    end

    always @(negedge clk) begin
        if (!s_csb) begin
            if (!s_web) begin
                for (int b = 0; b < MW; b++)
                    if (s_mask[b]) mem[s_addr][8*b +: 8] = s_din[8*b +: 8];
            end else begin
                dout0 <= mem[s_addr];
            end
        end
    end

    // ---------------- Protocol monitors ----------------
    int csb_low_cnt  = 0;
    int web_low_idle = 0;
    always @(negedge clk) begin
        if (csb0 === 1'b0) csb_low_cnt++;
        if (csb0 === 1'b1 && web0 !== 1'b1) web_low_idle++;
    end

    // ---------------- Checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Runs one request from handshake to response retirement. hold sets the
    // number of extra cycles resp_ready stays low after resp_valid rises.
    task automatic do_req(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [MW-1:0] m, input int hold, output logic [DW-1:0] rd);
        int n;
        int lat;
        int cs0;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("req_ready_idle", req_ready, 1);
        cs0        = csb_low_cnt;
        resp_ready = (hold == 0);
        req_valid  = 1'b1;
        req_write  = wr;
        req_addr   = a;
        req_wdata  = d;
        req_wmask  = m;
        @(negedge clk);                       // just after the accept edge
        req_valid = 1'b0;
        req_wdata = ~d;
        req_wmask = ~m;
        check("csb0_issue", csb0, 0);
        check("web0_issue", web0, !wr);
        check("addr0_issue", addr0, a);
        check("wmask0_issue", wmask0, wr ? m : '0);
        if (wr) check("din0_issue", din0, d);
        check("req_ready_busy", req_ready, 0);
        lat = 0;
        while (!resp_valid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        check(wr ? "latency_write" : "latency_read", lat, wr ? 1 : 2);
        check("resp_write", resp_write, wr);
        check("csb0_after_issue", csb0, 1);
        rd = resp_rdata;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", resp_valid, 1);
            check("hold_rdata", resp_rdata, rd);
            check("hold_req_ready", req_ready, 0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        check("resp_retired", resp_valid, 0);
        check("back_to_idle", req_ready, 1);
        check("csb_one_pulse", csb_low_cnt - cs0, 1);
    endtask

    logic [DW-1:0] rd;
    logic [DW-1:0] p_a5, p_mix, p_dead;

    initial begin
        p_a5   = {32{8'hA5}};
        p_mix  = {{28{8'hA5}}, {4{8'h3C}}};
        p_dead = {8{32'hDEADBEEF}};

        rst_n = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        req_wdata = '0; req_wmask = '0; resp_ready = 1'b1;
        repeat (3) @(negedge clk);

        // Reset values
        check("rst_csb0", csb0, 1);
        check("rst_web0", web0, 1);
        check("rst_wmask0", wmask0, 0);
        check("rst_addr0", addr0, 0);
        check("rst_din0", din0, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_write", resp_write, 0);
        check("rst_resp_rdata", resp_rdata, 0);
        check("rst_req_ready", req_ready, 0);

        // Idle for 10 cycles after reset is released
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_req_ready", req_ready, 1);
            check("idle_csb0", csb0, 1);
            check("idle_web0", web0, 1);
            check("idle_resp_valid", resp_valid, 0);
        end

        // Full-mask write, then read it back
        do_req(1'b1, 5'd5, p_a5, '1, 0, rd);
        do_req(1'b0, 5'd5, '1, '1, 0, rd);
        check("read_a5", rd, p_a5);

        // Partial write merges with the bytes it does not cover
        do_req(1'b1, 5'd5, {32{8'h3C}}, 32'h0000000F, 0, rd);
        do_req(1'b0, 5'd5, '0, '0, 0, rd);
        check("read_merge", rd, p_mix);

        // Read with back-pressure on the response
        do_req(1'b1, 5'd31, p_dead, '1, 0, rd);
        do_req(1'b0, 5'd31, '0, '0, 4, rd);
        check("read_held", rd, p_dead);

        // A write with an all-zero mask is still acknowledged and changes nothing
        do_req(1'b1, 5'd0, 256'h1, '1, 0, rd);
        do_req(1'b1, 5'd0, '1, '0, 0, rd);
        do_req(1'b0, 5'd0, '0, '0, 0, rd);
        check("read_zero_mask", rd, 256'h1);

        // Reset while the controller is in CAPT
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 5'd5;
        @(negedge clk);                       // after the accept edge (ISSUE)
        req_valid = 1'b0;
        @(negedge clk);                       // after E1 (CAPT)
        rst_n = 1'b0;
        @(negedge clk);                       // reset taken at E2
        check("mid_rst_resp_valid", resp_valid, 0);
        check("mid_rst_csb0", csb0, 1);
        check("mid_rst_req_ready", req_ready, 0);
        @(negedge clk);
        check("mid_rst_resp_valid2", resp_valid, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_resp_valid", resp_valid, 0);
        do_req(1'b0, 5'd5, '0, '0, 0, rd);
        check("post_rst_read", rd, p_mix);

        // Three writes and two reads in total since the last reset
        do_req(1'b1, 5'd1, {32{8'h11}}, '1, 0, rd);
        do_req(1'b1, 5'd2, {32{8'h22}}, '1, 0, rd);
        do_req(1'b1, 5'd3, {32{8'h33}}, 32'hFFFF0000, 0, rd);
        do_req(1'b0, 5'd3, '0, '0, 0, rd);
        check("read_upper_half", rd, {{16{8'h33}}, {16{8'h00}}});
`ifdef SRAM_PORT_STATS_EN
        check("stat_writes", stat_writes, 3);
        check("stat_reads", stat_reads, 2);
`endif

        check("web0_high_when_deselected", web_low_idle, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sram_port_master.md
Name: sram_port_master

Overview:
- Initiator/controller for the single-port, byte-masked cache data SRAM macros (32 x 256b, 8-bit write granularity).
- Accepts one read or write request at a time from the cache datapath over a valid/ready handshake.
- Sequences the SRAM chip-select, write-enable, mask, address and data pins to match the macro timing:
  - Inputs are captured at posedge.
  - Writes commit and dout updates at the following negedge.
- Returns read data or write acknowledgements over a valid/ready response channel.

Parameters:
ADDR_WIDTH, 5, SRAM word address width (depth = 2**ADDR_WIDTH)
DATA_WIDTH, 256, SRAM word width in bits
NUM_WMASKS, DATA_WIDTH/8, byte-lane write-mask width (derived, do not override)

Ports:
clk  in  1  clock (rising-edge logic)
rst_n  in  1  synchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  controller can accept a request
req_write  in  1  1 = write, 0 = read
req_addr  in  ADDR_WIDTH  word address
req_wdata  in  DATA_WIDTH  write data
req_wmask  in  NUM_WMASKS  byte-lane enables for writes
resp_valid  out  1  response present
resp_ready  in  1  consumer accepts response
resp_write  out  1  response is a write ack (1) or read data (0)
resp_rdata  out  DATA_WIDTH  read data (valid when resp_valid && !resp_write)
csb0  out  1  SRAM active-low chip select
web0  out  1  SRAM active-low write enable
wmask0  out  NUM_WMASKS  SRAM write mask
addr0  out  ADDR_WIDTH  SRAM address
din0  out  DATA_WIDTH  SRAM write data
dout0  in  DATA_WIDTH  SRAM read data

Behaviour:
- Reset (rst_n low at posedge):
  - State goes to IDLE.
  - csb0=1, web0=1, wmask0=0, addr0=0, din0=0.
  - resp_valid=0, resp_write=0, resp_rdata=0.
  - req_ready=0 while rst_n is low.
- All SRAM-side outputs are registered. csb0 is low for exactly one cycle per request and high at all other times. web0 is high whenever csb0 is high.
- FSM states: IDLE, ISSUE, CAPT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid at edge E0: latch the request and drive csb0=0, web0=!req_write, addr0=req_addr.
    - Writes: din0=req_wdata, wmask0=req_wmask.
    - Reads: wmask0=0.
  - Go to ISSUE.
- ISSUE (one cycle; the SRAM samples at E1):
  - At E1 drive csb0=1, web0=1.
  - Write: go to RESP with resp_valid=1, resp_write=1. The write commits at the negedge after E1.
  - Read: go to CAPT.
- CAPT (one cycle; dout0 settles at the negedge after E1):
  - At E2 capture resp_rdata=dout0 and set resp_valid=1, resp_write=0.
  - Go to RESP.
- RESP:
  - Hold resp_valid, resp_write and resp_rdata stable until resp_ready is high at an edge.
  - At that edge clear resp_valid and return to IDLE.
  - req_ready stays 0 in every state other than IDLE. There is no request overlap and no same-cycle accept.
- Latency from accept edge to resp_valid visible: read 2 cycles, write 1 cycle.
- Minimum accept-to-accept spacing: read 3 cycles, write 2 cycles. This guarantees a read following a write samples post-commit data.
- wmask all zeros on a write: the command is still issued, memory is unchanged, and an ack is still returned.
- req_wdata and req_wmask are ignored for reads.
- Read-after-write to the same address returns the newly written bytes merged with the old unmasked bytes.
- Reset mid-operation: the FSM returns to IDLE and any pending response is dropped. If reset asserts in the ISSUE cycle, the SRAM has already latched the command, so the write still commits. This is accepted behaviour.

Optional Feature:
- Macro: SRAM_PORT_STATS_EN.
- Defined:
  - Adds outputs stat_reads[31:0] and stat_writes[31:0].
  - Each counter increments by 1 at the accept edge of the corresponding request.
  - Both counters saturate at 32'hFFFF_FFFF and clear to 0 on reset.
- Undefined: the ports and counters are absent, and the block is otherwise identical.

Test Plan:
- Reset, then idle for 10 cycles -> csb0=1, web0=1, resp_valid=0 throughout; req_ready=1 from the first cycle after rst_n rises.
- Write addr 5, wdata all bytes 8'hA5, wmask 32'hFFFFFFFF, resp_ready=1, then read addr 5 -> write ack 1 cycle after accept; read data all 8'hA5, resp_valid 2 cycles after accept.
- Write addr 5, wdata all 8'h3C, wmask 32'h0000000F, then read addr 5 -> bytes 0-3 = 8'h3C, bytes 4-31 = 8'hA5.
- Read addr 31 with resp_ready held 0 for 4 cycles -> resp_valid and resp_rdata held stable, req_ready=0, and csb0 pulses low exactly once.
- Write addr 0 with wmask 0 after addr 0 holds 256'h1 -> ack returned; a subsequent read returns 256'h1.
- Assert rst_n=0 while in CAPT -> no response emitted, csb0=1, and the next request completes normally. With SRAM_PORT_STATS_EN, after 3 writes and 2 reads: stat_writes=3, stat_reads=2.
